// File: rtl/mac_vec.sv
// Streaming signed multiply-accumulate: two skew-tolerant operand FIFOs feed a
// registered product stage, a VEC_LEN-element accumulator and a valid/ready result register.
module mac_vec #(
   parameter int DW         = 4,
   parameter int VEC_LEN    = 8,
   parameter int ACC_W      = 2*DW + $clog2(VEC_LEN),
   parameter int FIFO_DEPTH = 4,
   parameter bit SAT        = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DW-1:0]    in_a,
   input  logic             in_valid_a,
   output logic             in_ready_a,
   input  logic [DW-1:0]    in_b,
   input  logic             in_valid_b,
   output logic             in_ready_b,
   output logic [ACC_W-1:0] mac_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

   logic [1:0][DW-1:0] w_in_data;
   logic [1:0][DW-1:0] w_rd_data;
   logic [1:0]         w_in_valid;
   logic [1:0]         w_full;
   logic [1:0]         w_empty;
   logic               w_pop;

   assign w_in_data  = {in_b, in_a};
   assign w_in_valid = {in_valid_b, in_valid_a};

   // Index 0 holds operand A, index 1 operand B; both FIFOs pop together.
   for (genvar s = 0; s < 2; s++) begin : g_fifo
      logic [DW-1:0] r_mem [FIFO_DEPTH];
      logic [AW:0]   r_wr_ptr;
      logic [AW:0]   r_rd_ptr;
      logic          w_push;

      assign w_full[s]    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
      assign w_empty[s]   = (r_wr_ptr == r_rd_ptr);
      assign w_push       = w_in_valid[s] && !w_full[s];
      assign w_rd_data[s] = r_mem[r_rd_ptr[AW-1:0]];

      // NOTE: sequential state is updated with non-blocking assignments only, so
      // every always_ff reads the pre-edge values regardless of evaluation order.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end

      // NOTE: storage is deliberately not reset; the pointers alone decide which
      // entries are live, and a reset memory would cost a mux per bit.
      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_in_data[s];
      end
   end

   assign in_ready_a = !w_full[0];
   assign in_ready_b = !w_full[1];

   logic signed [DW-1:0]    w_op_a;
   logic signed [DW-1:0]    w_op_b;
   logic signed [2*DW-1:0]  w_prod;
   logic signed [2*DW-1:0]  r_prod;
   logic                    r_prod_valid;
   logic [CW-1:0]           r_elem_cnt;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W:0]   w_sum_wide;
   logic signed [ACC_W-1:0] w_acc_next;
   logic [ACC_W-1:0]        r_mac_out;
   logic                    r_out_valid;
   logic                    w_last;
   logic                    w_commit;

   assign w_op_a = w_rd_data[0];
   assign w_op_b = w_rd_data[1];
   assign w_prod = w_op_a * w_op_b;

   // Only the final commit of a vector waits for the result register to free up.
   assign w_last   = (r_elem_cnt == CW'(VEC_LEN - 1));
   assign w_commit = r_prod_valid && !(w_last && r_out_valid && !out_ready);
   assign w_pop    = !w_empty[0] && !w_empty[1] && (!r_prod_valid || w_commit);

   assign w_prod_ext = ACC_W'(r_prod);
   assign w_sum_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_acc_next = w_sum_wide[ACC_W-1:0];
      if (r_elem_cnt == '0) begin
         w_acc_next = w_prod_ext;
      end else if (SAT && (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1])) begin
         w_acc_next = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prod_valid <= 1'b0;
         r_prod       <= '0;
         r_acc        <= '0;
         r_elem_cnt   <= '0;
         r_mac_out    <= '0;
         r_out_valid  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_prod_valid <= 1'b1;
            r_prod       <= w_prod;
         end else if (w_commit) begin
            r_prod_valid <= 1'b0;
         end

         if (w_commit) begin
            if (w_last) begin
               r_mac_out  <= w_acc_next;
               r_elem_cnt <= '0;
            end else begin
               r_acc      <= w_acc_next;
               r_elem_cnt <= r_elem_cnt + CW'(1);
            end
         end

         if (w_commit && w_last) r_out_valid <= 1'b1;
         else if (out_ready)     r_out_valid <= 1'b0;
      end
   end

   assign mac_out   = r_mac_out;
   assign out_valid = r_out_valid;
   assign busy      = !w_empty[0] || !w_empty[1] || r_prod_valid || (r_elem_cnt != '0);

endmodule

// File: tb/tb_mac_vec.sv
// Scoreboard bench for mac_vec: default build plus ACC_W=8 wrap and saturate builds
// share one stimulus stream; each keeps its own queue of expected results.
module tb_mac_vec;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in_a = '0;
   logic [3:0] in_b = '0;
   logic       in_valid_a = 1'b0;
   logic       in_valid_b = 1'b0;
   logic       out_ready = 1'b1;

   logic        in_ready_a0, in_ready_b0, out_valid0, busy0;
   logic [10:0] mac0;
   logic        in_ready_a1, in_ready_b1, out_valid1, busy1;
   logic [7:0]  mac1;
   logic        in_ready_a2, in_ready_b2, out_valid2, busy2;
   logic [7:0]  mac2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int q0[$];
   int q1[$];
   int q2[$];
   int hs_cyc[$];

   mac_vec u_dut0 (
      .clk(clk), .reset(reset),
      .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a0),
      .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b0),
      .mac_out(mac0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0)
   );

   mac_vec #(.ACC_W(8), .SAT(1'b0)) u_dut1 (
      .clk(clk), .reset(reset),
      .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a1),
      .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b1),
      .mac_out(mac1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
   );

   mac_vec #(.ACC_W(8), .SAT(1'b1)) u_dut2 (
      .clk(clk), .reset(reset),
      .in_a(in_a), .in_valid_a(in_valid_a), .in_ready_a(in_ready_a2),
      .in_b(in_b), .in_valid_b(in_valid_b), .in_ready_b(in_ready_b2),
      .mac_out(mac2), .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference dot product: per-addition clamp when saturating, modulo 2^w otherwise.
   function automatic int model(input int a[$], input int b[$], input int w, input bit sat);
      int acc = 0;
      int hi = (1 << (w - 1)) - 1;
      int lo = -(1 << (w - 1));
      for (int i = 0; i < a.size(); i++) begin
         acc = (i == 0) ? a[i] * b[i] : acc + a[i] * b[i];
         if (sat) begin
            if (acc > hi) acc = hi;
            else if (acc < lo) acc = lo;
         end
      end
      if (!sat) begin
         acc = acc & ((1 << w) - 1);
         if (acc > hi) acc = acc - (1 << w);
      end
      return acc;
   endfunction

   always @(negedge clk) begin
      if (!reset && out_valid0 && out_ready) begin
         checks++;
         hs_cyc.push_back(cyc);
         if (q0.size() == 0) begin
            failures++;
            $display("FAIL dut0_unexpected_result got=%0d required=none", $signed(mac0));
         end else if (int'($signed(mac0)) !== q0[0]) begin
            failures++;
            $display("FAIL dut0_result got=%0d required=%0d", $signed(mac0), q0[0]);
         end
         if (q0.size() != 0) void'(q0.pop_front());
      end
      if (!reset && out_valid1 && out_ready) begin
         checks++;
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL dut1_unexpected_result got=%0d required=none", $signed(mac1));
         end else if (int'($signed(mac1)) !== q1[0]) begin
            failures++;
            $display("FAIL dut1_wrap_result got=%0d required=%0d", $signed(mac1), q1[0]);
         end
         if (q1.size() != 0) void'(q1.pop_front());
      end
      if (!reset && out_valid2 && out_ready) begin
         checks++;
         if (q2.size() == 0) begin
            failures++;
            $display("FAIL dut2_unexpected_result got=%0d required=none", $signed(mac2));
         end else if (int'($signed(mac2)) !== q2[0]) begin
            failures++;
            $display("FAIL dut2_sat_result got=%0d required=%0d", $signed(mac2), q2[0]);
         end
         if (q2.size() != 0) void'(q2.pop_front());
      end
   end

   task automatic push_exp(input int a[$], input int b[$]);
      q0.push_back(model(a, b, 11, 1'b0));
      q1.push_back(model(a, b, 8, 1'b0));
      q2.push_back(model(a, b, 8, 1'b1));
   endtask

   task automatic drive_a(input int vals[$], input int max_gap);
      foreach (vals[i]) begin
         int t = 0;
         int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         in_a = 4'(vals[i]);
         in_valid_a = 1'b1;
         forever begin
            @(negedge clk);
            if (in_ready_a0) break;
            t++;
            if (t > 300) begin
               checks++;
               failures++;
               $display("FAIL push_a_timeout in_ready_a=%0b required=1", in_ready_a0);
               break;
            end
         end
         @(posedge clk);
         #1;
         in_valid_a = 1'b0;
      end
   endtask

   task automatic drive_b(input int vals[$], input int max_gap);
      foreach (vals[i]) begin
         int t = 0;
         int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         in_b = 4'(vals[i]);
         in_valid_b = 1'b1;
         forever begin
            @(negedge clk);
            if (in_ready_b0) break;
            t++;
            if (t > 300) begin
               checks++;
               failures++;
               $display("FAIL push_b_timeout in_ready_b=%0b required=1", in_ready_b0);
               break;
            end
         end
         @(posedge clk);
         #1;
         in_valid_b = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (busy0 || out_valid0 || q0.size() != 0) begin
         @(posedge clk);
         #1;
         t++;
         if (t > 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout busy=%0b out_valid=%0b pending=%0d required=idle",
                     busy0, out_valid0, q0.size());
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready_a0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_a got=%0b required=1", in_ready_a0); end
      checks++;
      if (in_ready_b0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready_b got=%0b required=1", in_ready_b0); end
      checks++;
      if (mac0 !== 11'd0) begin failures++; $display("FAIL reset_mac_out got=%0d required=0", mac0); end
      checks++;
      if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", out_valid0); end
      checks++;
      if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b required=0", busy0); end
      checks++;
      if ({in_ready_a1, in_ready_b1, in_ready_a2, in_ready_b2, busy1, busy2} !== 6'b111100) begin
         failures++;
         $display("FAIL reset_narrow_builds got=%b required=111100",
                  {in_ready_a1, in_ready_b1, in_ready_a2, in_ready_b2, busy1, busy2});
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_latency();
      int a[$];
      for (int i = 1; i <= 8; i++) a.push_back(i);
      push_exp(a, a);
      fork
         drive_a(a, 0);
         drive_b(a, 0);
      join
      checks++;
      if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b required=1", busy0); end
      // Last accept was edge E; out_valid must rise after E+2 and last one cycle.
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         checks++;
         if (out_valid0 !== (k == 2)) begin
            failures++;
            $display("FAIL basic_latency edge=E+%0d out_valid=%0b required=%0b", k, out_valid0, k == 2);
         end
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int a[$];
      int b[$];
      for (int i = 0; i < 8; i++) begin a.push_back(-8); b.push_back(-8); end
      q0.push_back(512); q1.push_back(0);   q2.push_back(127);
      for (int i = 0; i < 8; i++) begin a.push_back(-8); b.push_back(7); end
      q0.push_back(-448); q1.push_back(64); q2.push_back(-128);
      hs_cyc.delete();
      fork
         drive_a(a, 0);
         drive_b(b, 0);
      join
      wait_drain();
      checks++;
      if (hs_cyc.size() != 2) begin
         failures++;
         $display("FAIL b2b_result_count got=%0d required=2", hs_cyc.size());
      end else if (hs_cyc[1] - hs_cyc[0] != 8) begin
         failures++;
         $display("FAIL b2b_spacing got=%0d required=8", hs_cyc[1] - hs_cyc[0]);
      end
   endtask

   task automatic test_skew(input bit random_vals);
      int a[$];
      int a_head[$];
      int a_tail[$];
      int b[$];
      for (int i = 0; i < 8; i++) begin
         a.push_back(random_vals ? int'($urandom_range(0, 15)) - 8 : i + 1);
         b.push_back(random_vals ? int'($urandom_range(0, 15)) - 8 : i + 1);
         if (i < 4) a_head.push_back(a[i]);
         else       a_tail.push_back(a[i]);
      end
      push_exp(a, b);
      drive_a(a_head, 0);
      checks++;
      if (in_ready_a0 !== 1'b0) begin failures++; $display("FAIL skew_a_full_ready got=%0b required=0", in_ready_a0); end
      checks++;
      if (in_ready_b0 !== 1'b1) begin failures++; $display("FAIL skew_b_ready got=%0b required=1", in_ready_b0); end
      fork
         drive_a(a_tail, 3);
         drive_b(b, 3);
      join
      wait_drain();
   endtask

   task automatic test_backpressure();
      int v1a[$], v1b[$], v2a[$], v2b[$], v3a[$], v3b[$];
      int sa[$], sb[$], ta[$], tb[$];
      int held;
      for (int i = 0; i < 8; i++) begin
         v1a.push_back(int'($urandom_range(0, 15)) - 8); v1b.push_back(int'($urandom_range(0, 15)) - 8);
         v2a.push_back(int'($urandom_range(0, 15)) - 8); v2b.push_back(int'($urandom_range(0, 15)) - 8);
         v3a.push_back(int'($urandom_range(0, 15)) - 8); v3b.push_back(int'($urandom_range(0, 15)) - 8);
      end
      foreach (v1a[i]) begin sa.push_back(v1a[i]); sb.push_back(v1b[i]); end
      foreach (v2a[i]) begin sa.push_back(v2a[i]); sb.push_back(v2b[i]); end
      for (int i = 0; i < 4; i++) begin sa.push_back(v3a[i]); sb.push_back(v3b[i]); end
      for (int i = 4; i < 8; i++) begin ta.push_back(v3a[i]); tb.push_back(v3b[i]); end
      held = model(v1a, v1b, 11, 1'b0);
      push_exp(v1a, v1b);
      push_exp(v2a, v2b);
      out_ready = 1'b0;
      fork
         drive_a(sa, 0);
         drive_b(sb, 0);
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready_a0 !== 1'b0) begin failures++; $display("FAIL bp_in_ready_a got=%0b required=0", in_ready_a0); end
      checks++;
      if (in_ready_b0 !== 1'b0) begin failures++; $display("FAIL bp_in_ready_b got=%0b required=0", in_ready_b0); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid0 !== 1'b1 || int'($signed(mac0)) !== held) begin
            failures++;
            $display("FAIL bp_held cycle=%0d out_valid=%0b mac_out=%0d required=1/%0d",
                     k, out_valid0, $signed(mac0), held);
         end
         @(posedge clk);
         #1;
      end
      push_exp(v3a, v3b);
      out_ready = 1'b1;
      fork
         drive_a(ta, 0);
         drive_b(tb, 0);
      join
      wait_drain();
   endtask

   task automatic test_reset_mid_vector();
      int ones[$];
      int a[$];
      int b[$];
      for (int i = 0; i < 5; i++) ones.push_back(1);
      for (int i = 0; i < 8; i++) begin a.push_back(2); b.push_back(3); end
      fork
         drive_a(ones, 0);
         drive_b(ones, 0);
      join
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (busy0 !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%0b required=0", busy0); end
      checks++;
      if (out_valid0 !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%0b required=0", out_valid0); end
      checks++;
      if ({in_ready_a0, in_ready_b0} !== 2'b11) begin
         failures++;
         $display("FAIL midreset_ready got=%b required=11", {in_ready_a0, in_ready_b0});
      end
      q0.push_back(48); q1.push_back(48); q2.push_back(48);
      fork
         drive_a(a, 0);
         drive_b(b, 0);
      join
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_back_to_back();
      test_skew(1'b0);
      test_skew(1'b1);
      test_backpressure();
      test_reset_mid_vector();
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d/%0d/%0d required=0/0/0", q0.size(), q1.size(), q2.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
